// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer that drives an external return stack.
// It selects the next PC from ret/call/jump/branch/sequential in priority
// order, issues push/pop requests, tracks stack occupancy and latches a
// sticky fault on stack overflow or underflow.
module pc_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          call,
  input  logic          ret,
  input  logic          jump,
  input  logic          br_taken,
  input  logic [AW-1:0] target,
  input  logic [AW-1:0] stack_top,
  output logic [AW-1:0] pc,
  output logic          stack_push,
  output logic          stack_pop,
  output logic [AW-1:0] stack_wdata,
  output logic [3:0]    depth,
  output logic          fault
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [3:0]    depth_q, depth_d;
  logic [AW-1:0] pc_inc;

  // Sequential successor; the add truncates to AW bits, so 0xFFF wraps to 0.
  assign pc_inc = pc_q + AW'(1);

  // Next-state, next-PC, occupancy and stack request decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    depth_d    = depth_q;
    stack_push = 1'b0;
    stack_pop  = 1'b0;

    // Reset, stall and FAULT all freeze the sequencer and silence the stack.
    if (!rst && !stall && (state_q == RUN)) begin
      if (ret) begin
        if (depth_q == 4'd0) begin
          // Underflow: no pop, PC held, fault from the next edge on.
          state_d = FAULT;
        end else begin
          stack_pop = 1'b1;
          pc_d      = stack_top;
          depth_d   = depth_q - 4'd1;
        end
      end else if (call) begin
        if (depth_q == 4'(DEPTH)) begin
          // Overflow: no push, PC held, fault from the next edge on.
          state_d = FAULT;
        end else begin
          stack_push = 1'b1;
          pc_d       = target;
          depth_d    = depth_q + 4'd1;
        end
      end else if (jump || br_taken) begin
        pc_d = target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // State, PC and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with non-blocking <= so every
    // register samples its pre-edge value regardless of statement order.
    if (rst) begin
      state_q <= RUN;
      pc_q    <= '0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
    end
  end

  assign pc          = pc_q;
  assign depth       = depth_q;
  assign fault       = (state_q == FAULT);
  assign stack_wdata = pc_inc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_pc_sequencer;

  localparam int AW = 12;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          call;
  logic          ret;
  logic          jump;
  logic          br_taken;
  logic [AW-1:0] target;
  logic [AW-1:0] stack_top;
  logic [AW-1:0] pc;
  logic          stack_push;
  logic          stack_pop;
  logic [AW-1:0] stack_wdata;
  logic [3:0]    depth;
  logic          fault;

  int checks;
  int failures;

  pc_sequencer #(.DEPTH(8), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .call        (call),
    .ret         (ret),
    .jump        (jump),
    .br_taken    (br_taken),
    .target      (target),
    .stack_top   (stack_top),
    .pc          (pc),
    .stack_push  (stack_push),
    .stack_pop   (stack_pop),
    .stack_wdata (stack_wdata),
    .depth       (depth),
    .fault       (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle 1 ns after it before anything is sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; call = 0; ret = 0; jump = 0; br_taken = 0;
    target = '0; stack_top = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; call = 1; ret = 0; target = 12'h0AA;
    #1;
    checks++; if (stack_push !== 1'b0) begin failures++; $display("FAIL reset_push actual=%0b expected=0", stack_push); end
    rst = 1; call = 0; ret = 1;
    #1;
    checks++; if (stack_pop !== 1'b0) begin failures++; $display("FAIL reset_pop actual=%0b expected=0", stack_pop); end
    stall = 1;
    tick(); tick();
    checks++; if (pc !== 12'h000) begin failures++; $display("FAIL reset_pc actual=%h expected=000", pc); end
    checks++; if (depth !== 4'd0) begin failures++; $display("FAIL reset_depth actual=%0d expected=0", depth); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault actual=%0b expected=0", fault); end
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      checks++; if (stack_push !== 1'b0 || stack_pop !== 1'b0) begin failures++; $display("FAIL seq_req step=%0d push=%0b pop=%0b expected=0/0", i, stack_push, stack_pop); end
      tick();
      checks++; if (pc !== AW'(i)) begin failures++; $display("FAIL seq_pc step=%0d actual=%h expected=%h", i, pc, AW'(i)); end
      checks++; if (depth !== 4'd0) begin failures++; $display("FAIL seq_depth step=%0d actual=%0d expected=0", i, depth); end
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    jump = 1; target = 12'h005;
    tick();
    jump = 0;
    checks++; if (pc !== 12'h005) begin failures++; $display("FAIL cr_setup_pc actual=%h expected=005", pc); end
    call = 1; target = 12'h040;
    #1;
    checks++; if (stack_push !== 1'b1 || stack_pop !== 1'b0) begin failures++; $display("FAIL cr_call_req push=%0b pop=%0b expected=1/0", stack_push, stack_pop); end
    checks++; if (stack_wdata !== 12'h006) begin failures++; $display("FAIL cr_wdata actual=%h expected=006", stack_wdata); end
    tick();
    call = 0;
    checks++; if (pc !== 12'h040 || depth !== 4'd1) begin failures++; $display("FAIL cr_after_call pc=%h depth=%0d expected=040/1", pc, depth); end
    ret = 1; stack_top = 12'h006;
    #1;
    checks++; if (stack_pop !== 1'b1 || stack_push !== 1'b0) begin failures++; $display("FAIL cr_ret_req push=%0b pop=%0b expected=0/1", stack_push, stack_pop); end
    tick();
    ret = 0;
    checks++; if (pc !== 12'h006 || depth !== 4'd0) begin failures++; $display("FAIL cr_after_ret pc=%h depth=%0d expected=006/0", pc, depth); end
  endtask

  task automatic test_branch();
    do_reset();
    br_taken = 1; target = 12'h123;
    #1;
    checks++; if (stack_push !== 1'b0 || stack_pop !== 1'b0) begin failures++; $display("FAIL br_req push=%0b pop=%0b expected=0/0", stack_push, stack_pop); end
    tick();
    br_taken = 0;
    checks++; if (pc !== 12'h123 || depth !== 4'd0) begin failures++; $display("FAIL br_pc pc=%h depth=%0d expected=123/0", pc, depth); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      call = 1; target = 12'h100 + AW'(i);
      #1;
      checks++; if (stack_push !== 1'b1) begin failures++; $display("FAIL ovf_push call=%0d actual=%0b expected=1", i, stack_push); end
      tick();
      checks++; if (depth !== 4'(i + 1)) begin failures++; $display("FAIL ovf_depth call=%0d actual=%0d expected=%0d", i, depth, i + 1); end
    end
    call = 1; target = 12'h200;
    #1;
    checks++; if (stack_push !== 1'b0) begin failures++; $display("FAIL ovf_ninth_push actual=%0b expected=0", stack_push); end
    tick();
    call = 0;
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL ovf_fault actual=%0b expected=1", fault); end
    checks++; if (pc !== 12'h107 || depth !== 4'd8) begin failures++; $display("FAIL ovf_hold pc=%h depth=%0d expected=107/8", pc, depth); end
    ret = 1; call = 1; jump = 1; target = 12'h300; stack_top = 12'h222;
    #1;
    checks++; if (stack_push !== 1'b0 || stack_pop !== 1'b0) begin failures++; $display("FAIL ovf_ignored_req push=%0b pop=%0b expected=0/0", stack_push, stack_pop); end
    tick();
    ret = 0; call = 0; jump = 0;
    tick();
    checks++; if (pc !== 12'h107 || depth !== 4'd8 || fault !== 1'b1) begin failures++; $display("FAIL ovf_ignored pc=%h depth=%0d fault=%0b expected=107/8/1", pc, depth, fault); end
  endtask

  task automatic test_underflow();
    do_reset();
    jump = 1; target = 12'h010;
    tick();
    jump = 0;
    ret = 1; stack_top = 12'h055;
    #1;
    checks++; if (stack_pop !== 1'b0) begin failures++; $display("FAIL unf_pop actual=%0b expected=0", stack_pop); end
    tick();
    ret = 0;
    checks++; if (fault !== 1'b1 || pc !== 12'h010) begin failures++; $display("FAIL unf_fault fault=%0b pc=%h expected=1/010", fault, pc); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if (pc !== 12'h000 || fault !== 1'b0 || depth !== 4'd0) begin failures++; $display("FAIL unf_reset pc=%h fault=%0b depth=%0d expected=000/0/0", pc, fault, depth); end
  endtask

  task automatic test_priority();
    do_reset();
    call = 1; target = 12'h020;
    tick();
    target = 12'h030;
    tick();
    call = 0;
    checks++; if (pc !== 12'h030 || depth !== 4'd2) begin failures++; $display("FAIL pri_setup pc=%h depth=%0d expected=030/2", pc, depth); end
    stall = 1; call = 1; ret = 1; jump = 1; target = 12'h0F0; stack_top = 12'h021;
    #1;
    checks++; if (stack_push !== 1'b0 || stack_pop !== 1'b0) begin failures++; $display("FAIL pri_stall_req push=%0b pop=%0b expected=0/0", stack_push, stack_pop); end
    tick();
    checks++; if (pc !== 12'h030 || depth !== 4'd2 || fault !== 1'b0) begin failures++; $display("FAIL pri_stall_hold pc=%h depth=%0d fault=%0b expected=030/2/0", pc, depth, fault); end
    stall = 0;
    #1;
    checks++; if (stack_pop !== 1'b1 || stack_push !== 1'b0) begin failures++; $display("FAIL pri_req push=%0b pop=%0b expected=0/1", stack_push, stack_pop); end
    tick();
    call = 0; ret = 0; jump = 0;
    checks++; if (pc !== 12'h021 || depth !== 4'd1) begin failures++; $display("FAIL pri_ret pc=%h depth=%0d expected=021/1", pc, depth); end
    call = 1; jump = 1; target = 12'h0B0;
    #1;
    checks++; if (stack_push !== 1'b1) begin failures++; $display("FAIL pri_call_over_jump push=%0b expected=1", stack_push); end
    tick();
    call = 0; jump = 0;
    checks++; if (pc !== 12'h0B0 || depth !== 4'd2) begin failures++; $display("FAIL pri_call pc=%h depth=%0d expected=0B0/2", pc, depth); end
  endtask

  task automatic test_wrap();
    do_reset();
    jump = 1; target = 12'hFFF;
    tick();
    jump = 0;
    tick();
    checks++; if (pc !== 12'h000) begin failures++; $display("FAIL wrap_pc actual=%h expected=000", pc); end
    jump = 1; target = 12'hFFF;
    tick();
    jump = 0;
    call = 1; target = 12'h080;
    #1;
    checks++; if (stack_push !== 1'b1 || stack_wdata !== 12'h000) begin failures++; $display("FAIL wrap_wdata push=%0b wdata=%h expected=1/000", stack_push, stack_wdata); end
    tick();
    call = 0;
    checks++; if (pc !== 12'h080 || depth !== 4'd1) begin failures++; $display("FAIL wrap_call pc=%h depth=%0d expected=080/1", pc, depth); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_call_ret();
    test_branch();
    test_overflow();
    test_underflow();
    test_priority();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
